mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the CPU's single 8-bit, 256-entry memory between two requesters: the CPU fetch/operand path (port 0) and a program loader or debug master (port 1). It grants at most one access per cycle and drives the memory address, write data and write enable. Read data is returned registered, one cycle after grant. Consecutive grants to one port are bounded by a hold limit, so neither requester can starve the other.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: memory data width.
- `MAX_HOLD`, default 4: max consecutive grants to one port while the other port is requesting. Legal range 1..15.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0` / `req1` in 1: access request. Held high until the matching `gnt` is seen.
- `we0` / `we1` in 1: 1 = write, 0 = read. Sampled with the request.
- `addr0` / `addr1` in `ADDR_W`: access address.
- `wdata0` / `wdata1` in `DATA_W`: write data.
- `gnt0` / `gnt1` out 1: access performed this cycle. Combinational from registered state and `req*`.
- `rvalid0` / `rvalid1` out 1: registered; read data valid, one cycle after a read grant.
- `rdata0` / `rdata1` out `DATA_W`: registered read data. Holds its value until the next read by that port.
- `mem_addr` out `ADDR_W`: address to memory.
- `mem_wdata` out `DATA_W`: write data to memory.
- `mem_we` out 1: write enable; memory writes on the rising edge when high.
- `mem_rdata` in `DATA_W`: memory read data, combinational from `mem_addr`.
- `owner` out 2: registered; 0 = idle, 1 = port 0 owns, 2 = port 1 owns.

## Operation
- **State**
  - `owner` register: IDLE / OWN0 / OWN1.
  - `last` pointer (1 bit): last port granted.
  - `hold_cnt` (4 bits): saturating count of consecutive grants to the current owner.
- **Grant decision** (combinational, each cycle):
  - If the current owner is requesting and (the other port is not requesting, or `hold_cnt < MAX_HOLD`): grant the owner.
  - Else if the other port is requesting: grant the other port (switch).
  - Else if in IDLE with both ports requesting: grant the port not equal to `last`.
  - Else if in IDLE with one port requesting: grant that port.
  - Else: no grant.
- **Exclusivity:** at most one of `gnt0`/`gnt1` is high in any cycle.
- **Memory mux**
  - On a grant, `mem_addr`, `mem_wdata` and `mem_we` follow the granted port.
  - With no grant: `mem_we` = 0, and `mem_addr`/`mem_wdata` hold the last granted port's values.
- **Register updates on the edge**
  - Grant to the same owner: `hold_cnt` += 1, saturating at 15.
  - Grant to a new port: `owner` = that port, `hold_cnt` = 1, `last` = that port.
  - No grant: `owner` = IDLE, `hold_cnt` = 0, `last` unchanged.
- **Read return:** a read grant to port p captures `mem_rdata` into `rdata_p` and sets `rvalid_p` = 1 for exactly the next cycle.
- **Write:** no `rvalid` is produced.
- **Requester rule:** a port may drop `req` only after seeing `gnt`. It may change `addr`/`we`/`wdata` in the cycle after `gnt` to issue the next access. Behaviour when `req` is withdrawn without a grant: the request is simply not performed; no error is raised.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `owner` = IDLE, `last` = 1 (so port 0 wins the first contention), `hold_cnt` = 0.
  - `rvalid0` = `rvalid1` = 0, `rdata0` = `rdata1` = 0.
  - `gnt0` = `gnt1` = 0 and `mem_we` = 0 while `rst_n` is low, regardless of `req`.
  - `mem_addr` = 0 and `mem_wdata` = 0.
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` when the port wins.
- Read data latency: `rvalid`/`rdata` valid in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle. A single requester gets back-to-back grants indefinitely (the hold limit applies only under contention).
- Contention with both ports requesting continuously: grants alternate in bursts of `MAX_HOLD`.
- `MAX_HOLD` = 1 degenerates to strict round-robin.
- Reset asserted mid-read: the pending `rvalid` is cleared and is not produced after reset release.
- Reset asserted mid-write: whether the write completes depends on whether the edge occurred before `rst_n` fell; the arbiter guarantees `mem_we` = 0 from `rst_n` low onward.
- Same-cycle write and read at one address from the two ports is impossible, since only one port is granted per cycle.

## Test plan
- **Single read:** reset, then `req0` = 1, `we0` = 0, `addr0` = 0x05 with memory[5] = 0x2A.
  - `gnt0` = 1 in the same cycle; `rvalid0` = 1 and `rdata0` = 0x2A the next cycle; `owner` = 1.
- **Write then read:** port 1 writes 0x7F to 0x10, then reads 0x10.
  - `mem_we` = 1 only in the write grant cycle; the read returns `rdata1` = 0x7F; `rvalid1` pulses only for the read.
- **Contention with `MAX_HOLD` = 4:** `req0` and `req1` both held high for 12 cycles from reset.
  - Grant sequence is 0,0,0,0,1,1,1,1,0,0,0,0.
  - `gnt0` & `gnt1` is never high together.
- **Owner release:** port 0 holds for 2 grants, then drops `req0` while `req1` rises.
  - Port 1 is granted in the first cycle after port 0 drops; `hold_cnt` = 1.
  - With no requests, the next cycle has `owner` = 0 and `mem_we` = 0.
- **Idle tie-break:** after a last grant to port 0 and one idle cycle, both ports request. Port 1 wins first.
- **Reset mid-operation:** assert `rst_n` = 0 in the cycle after a read grant.
  - `rvalid` goes to 0 immediately, and all registered outputs and state take their reset values.
  - After release with both ports requesting, port 0 wins first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the shared memory.
// The arbiter takes the slave view; the requesters/memory side take the master view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported memory: one access per cycle, zero-latency
// grant, registered read return, and a hold limit that bounds bursts under contention.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } owner_e;

  localparam logic [3:0] HoldLimit = 4'(MAX_HOLD);

  owner_e            owner_q, owner_d, new_owner;
  logic              last_q, last_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              gnt0, gnt1, hold_ok;
  logic              rd0, rd1;

  assign hold_ok = hold_cnt_q < HoldLimit;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (owner_q)
      StOwn0: begin
        if (bus.req0 && (!bus.req1 || hold_ok)) gnt0 = 1'b1;
        else if (bus.req1)                      gnt1 = 1'b1;
      end
      StOwn1: begin
        if (bus.req1 && (!bus.req0 || hold_ok)) gnt1 = 1'b1;
        else if (bus.req0)                      gnt0 = 1'b1;
      end
      default: begin
        // Idle tie-break favours the port that was not granted last.
        if (bus.req0 && bus.req1) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = bus.req0;
          gnt1 = bus.req1;
        end
      end
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    new_owner  = gnt0 ? StOwn0 : StOwn1;
    if (gnt0 || gnt1) begin
      if (new_owner == owner_q) begin
        hold_cnt_d = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;
      end else begin
        owner_d    = new_owner;
        hold_cnt_d = 4'd1;
        last_d     = gnt1;
      end
    end else begin
      owner_d    = StIdle;
      hold_cnt_d = 4'd0;
    end
  end

  assign rd0 = gnt0 && !bus.we0;
  assign rd1 = gnt1 && !bus.we1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= StIdle;
      last_q     <= 1'b1;
      hold_cnt_q <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= bus.mem_addr;
      wdata_q    <= bus.mem_wdata;
      rvalid0_q  <= rd0;
      rvalid1_q  <= rd1;
      if (rd0) rdata0_q <= bus.mem_rdata;
      if (rd1) rdata1_q <= bus.mem_rdata;
    end
  end

  // Without a grant the memory bus parks on the last granted access.
  assign bus.mem_addr  = gnt0 ? bus.addr0  : (gnt1 ? bus.addr1  : addr_q);
  assign bus.mem_wdata = gnt0 ? bus.wdata0 : (gnt1 ? bus.wdata1 : wdata_q);
  assign bus.mem_we    = (gnt0 && bus.we0) || (gnt1 && bus.we1);

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, read-return scoreboard and directed scenarios.
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned MH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seed(input int i);
    return (i == 5) ? 8'h2A : 8'(i * 7 + 3);
  endfunction

  // Memory device: combinational read, write on the rising edge.
  logic [DW-1:0] mem [256];
  logic          mem_ready = 1'b0;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Scoreboard: golden memory plus per-port queues of read data expected next cycle.
  logic [DW-1:0] ref_mem [256];
  logic          ref_ready = 1'b0;
  logic [DW-1:0] exp0_q [$];
  logic [DW-1:0] exp1_q [$];
  logic          exp_we;

  always @(negedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
      ref_ready = 1'b1;
    end
    if (!rst_n) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      check_eq("excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (exp0_q.size() != 0) begin
        check_eq("rvalid0", 32'(bus.rvalid0), 32'd1);
        check_eq("rdata0", 32'(bus.rdata0), 32'(exp0_q.pop_front()));
      end else begin
        check_eq("rvalid0_quiet", 32'(bus.rvalid0), 32'd0);
      end
      if (exp1_q.size() != 0) begin
        check_eq("rvalid1", 32'(bus.rvalid1), 32'd1);
        check_eq("rdata1", 32'(bus.rdata1), 32'(exp1_q.pop_front()));
      end else begin
        check_eq("rvalid1_quiet", 32'(bus.rvalid1), 32'd0);
      end
      exp_we = (bus.gnt0 && bus.we0) || (bus.gnt1 && bus.we1);
      check_eq("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (bus.gnt0) begin
        if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
        else         exp0_q.push_back(ref_mem[bus.addr0]);
      end
      if (bus.gnt1) begin
        if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
        else         exp1_q.push_back(ref_mem[bus.addr1]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.we0    = 1'b0;
    bus.we1    = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  logic [11:0] exp_seq;

  initial begin
    idle_all();
    #2;
    // Requests during reset must not produce grants or writes.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h33; bus.wdata0 = 8'h44;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h55; bus.wdata1 = 8'h66;
    #1;
    check_eq("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check_eq("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_owner", 32'(bus.owner), 32'd0);
    check_eq("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_eq("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check_eq("rst_rdata0", 32'(bus.rdata0), 32'd0);
    check_eq("rst_rdata1", 32'(bus.rdata1), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    idle_all();
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single read of address 5.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
    smp();
    check_eq("rd_gnt0", 32'(bus.gnt0), 32'd1);
    check_eq("rd_gnt1", 32'(bus.gnt1), 32'd0);
    check_eq("rd_owner_pre", 32'(bus.owner), 32'd0);
    cyc();
    bus.req0 = 1'b0;
    smp();
    check_eq("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_eq("rd_rdata0", 32'(bus.rdata0), 32'h2A);
    check_eq("rd_owner", 32'(bus.owner), 32'd1);
    cyc();

    // Port 1 writes 0x7F to 0x10, then reads it back.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h10; bus.wdata1 = 8'h7F;
    smp();
    check_eq("wr_gnt1", 32'(bus.gnt1), 32'd1);
    check_eq("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
    check_eq("wr_mem_wdata", 32'(bus.mem_wdata), 32'h7F);
    cyc();
    bus.we1 = 1'b0;
    smp();
    check_eq("rb_gnt1", 32'(bus.gnt1), 32'd1);
    check_eq("rb_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rb_no_rvalid", 32'(bus.rvalid1), 32'd0);
    cyc();
    bus.req1 = 1'b0;
    smp();
    check_eq("rb_rvalid1", 32'(bus.rvalid1), 32'd1);
    check_eq("rb_rdata1", 32'(bus.rdata1), 32'h7F);
    check_eq("park_mem_addr", 32'(bus.mem_addr), 32'h10);
    check_eq("park_gnt1", 32'(bus.gnt1), 32'd0);
    cyc();
    smp();
    check_eq("rb_rvalid1_off", 32'(bus.rvalid1), 32'd0);
    check_eq("rb_owner_idle", 32'(bus.owner), 32'd0);
    cyc();

    // Continuous contention from reset: bursts of MAX_HOLD.
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 8'h20;
    bus.req1 = 1'b1; bus.addr1 = 8'h30;
    exp_seq = 12'h0F0;
    for (int i = 0; i < 12; i++) begin
      smp();
      check_eq($sformatf("cont_gnt1_%0d", i), 32'(bus.gnt1), 32'(exp_seq[i]));
      check_eq($sformatf("cont_gnt0_%0d", i), 32'(bus.gnt0), 32'(!exp_seq[i]));
      cyc();
    end
    idle_all();
    smp();
    cyc();

    // Owner release: port 0 holds two grants, then port 1 takes over.
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 8'h01;
    for (int i = 0; i < 2; i++) begin
      smp();
      check_eq("rel_gnt0", 32'(bus.gnt0), 32'd1);
      cyc();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 8'h02;
    smp();
    check_eq("rel_gnt1", 32'(bus.gnt1), 32'd1);
    check_eq("rel_gnt0_off", 32'(bus.gnt0), 32'd0);
    cyc();
    bus.req1 = 1'b0;
    smp();
    check_eq("rel_owner1", 32'(bus.owner), 32'd2);
    check_eq("rel_hold", 32'(dut.hold_cnt_q), 32'd1);
    cyc();
    smp();
    check_eq("rel_owner_idle", 32'(bus.owner), 32'd0);
    check_eq("rel_mem_we", 32'(bus.mem_we), 32'd0);
    cyc();

    // Idle tie-break: last grant to port 0, one idle cycle, then both request.
    bus.req0 = 1'b1; bus.addr0 = 8'h03;
    smp();
    check_eq("tb_gnt0", 32'(bus.gnt0), 32'd1);
    cyc();
    bus.req0 = 1'b0;
    smp();
    check_eq("tb_idle", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    cyc();
    bus.req0 = 1'b1; bus.addr0 = 8'h04;
    bus.req1 = 1'b1; bus.addr1 = 8'h06;
    smp();
    check_eq("tb_first_gnt1", 32'(bus.gnt1), 32'd1);
    check_eq("tb_first_gnt0", 32'(bus.gnt0), 32'd0);
    cyc();
    smp();
    check_eq("tb_hold_gnt1", 32'(bus.gnt1), 32'd1);
    cyc();
    idle_all();
    smp();
    cyc();

    // Reset in the cycle after a read grant.
    bus.req0 = 1'b1; bus.addr0 = 8'h07;
    smp();
    check_eq("mid_gnt0", 32'(bus.gnt0), 32'd1);
    cyc();
    bus.req0 = 1'b0;
    check_eq("mid_rvalid_pre", 32'(bus.rvalid0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_eq("mid_rdata0", 32'(bus.rdata0), 32'd0);
    check_eq("mid_owner", 32'(bus.owner), 32'd0);
    check_eq("mid_hold", 32'(dut.hold_cnt_q), 32'd0);
    check_eq("mid_last", 32'(dut.last_q), 32'd1);
    check_eq("mid_mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.req0 = 1'b1; bus.addr0 = 8'h08;
    bus.req1 = 1'b1; bus.addr1 = 8'h09;
    smp();
    check_eq("mid_rst_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    cyc();
    rst_n = 1'b1;
    smp();
    check_eq("post_gnt0", 32'(bus.gnt0), 32'd1);
    check_eq("post_gnt1", 32'(bus.gnt1), 32'd0);
    cyc();
    idle_all();
    smp();
    cyc();
    smp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
